// File: rtl/apply_result_return_pkg.sv
// Shared types and default sizing for the apply result-return reorder buffer.
package apply_result_return_pkg;

    localparam int ARR_DEPTH = 8;   // slots in flight, power of two
    localparam int ARR_TAG_W = 3;   // log2(ARR_DEPTH)
    localparam int ARR_IDX_W = 30;  // BDD node index width

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slotState_t;

    // Decode the per-slot valid/done bit pair into its lifecycle state.
    function automatic slotState_t getSlotState(input logic valid, input logic done);
        if (!valid) return SLOT_FREE;
        if (!done)  return SLOT_PENDING;
        return SLOT_DONE;
    endfunction

endpackage

// File: rtl/apply_result_return_if.sv
// Issue / completion / response bundle of the apply result-return buffer.
// The slave modport is the buffer itself; master is the surrounding logic.
interface apply_result_return_if
    import apply_result_return_pkg::*;
#(
    parameter int TAG_W = ARR_TAG_W,
    parameter int IDX_W = ARR_IDX_W
) ();

    logic             issue_valid;
    logic             issue_ready;
    logic             issue_hit;
    logic [IDX_W-1:0] issue_result;
    logic [TAG_W-1:0] issue_tag;
    logic             cmp_valid;
    logic [TAG_W-1:0] cmp_tag;
    logic [IDX_W-1:0] cmp_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDX_W-1:0] rsp_result;
    logic [TAG_W:0]   occupancy;
    logic             err_cmp;

    modport slave (
        input  issue_valid, issue_hit, issue_result,
        input  cmp_valid, cmp_tag, cmp_result,
        input  rsp_ready,
        output issue_ready, issue_tag,
        output rsp_valid, rsp_result,
        output occupancy, err_cmp
    );

    modport master (
        output issue_valid, issue_hit, issue_result,
        output cmp_valid, cmp_tag, cmp_result,
        output rsp_ready,
        input  issue_ready, issue_tag,
        input  rsp_valid, rsp_result,
        input  occupancy, err_cmp
    );

endinterface

// File: rtl/apply_result_return.sv
// In-order return buffer for apply requests: hits arrive already resolved,
// misses are completed out of order by the apply engine via their slot tag,
// and responses leave strictly in issue order.
module apply_result_return
    import apply_result_return_pkg::*;
#(
    parameter int DEPTH = ARR_DEPTH,
    parameter int TAG_W = ARR_TAG_W,
    parameter int IDX_W = ARR_IDX_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    apply_result_return_if.slave bus
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] headPtr;
    logic [TAG_W-1:0] tailPtr;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] slotValid;
    logic [DEPTH-1:0] slotDone;
    logic [IDX_W-1:0] slotResult [DEPTH];
    logic             errCmp;

    logic             issueFire;
    logic             popFire;
    logic             cmpAccept;

    // All outputs come straight from flops; ready depends only on the
    // registered count, so a pop never frees a slot for the same cycle.
    assign bus.issue_ready = (count != FULL_COUNT);
    assign bus.issue_tag   = tailPtr;
    assign bus.rsp_valid   = slotDone[headPtr];
    assign bus.rsp_result  = slotResult[headPtr];
    assign bus.occupancy   = count;
    assign bus.err_cmp     = errCmp;

    assign issueFire = bus.issue_valid & bus.issue_ready;
    assign popFire   = bus.rsp_valid & bus.rsp_ready;
    assign cmpAccept = bus.cmp_valid &&
                       (getSlotState(slotValid[bus.cmp_tag], slotDone[bus.cmp_tag]) == SLOT_PENDING);

    // Head/tail pointers wrap naturally at DEPTH; count tracks issue minus pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (issueFire) tailPtr <= tailPtr + 1'b1;
            if (popFire)   headPtr <= headPtr + 1'b1;
            case ({issueFire, popFire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot array: completion, pop and issue always touch distinct slots
    // (pending, done and free respectively), so all three can land together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slotValid <= '0;
            slotDone  <= '0;
            errCmp    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) slotResult[i] <= '0;
        end else begin
            if (cmpAccept) begin
                slotDone[bus.cmp_tag]   <= 1'b1;
                slotResult[bus.cmp_tag] <= bus.cmp_result;
            end else if (bus.cmp_valid) begin
                errCmp <= 1'b1;
            end
            if (popFire) begin
                slotValid[headPtr]  <= 1'b0;
                slotDone[headPtr]   <= 1'b0;
                slotResult[headPtr] <= '0;
            end
            if (issueFire) begin
                slotValid[tailPtr]  <= 1'b1;
                slotDone[tailPtr]   <= bus.issue_hit;
                slotResult[tailPtr] <= bus.issue_hit ? bus.issue_result : '0;
            end
        end
    end

endmodule

// File: tb/tb_apply_result_return.sv
// Directed bench for apply_result_return: a per-cycle vector table for the
// in-order return paths, then hand-written fill/wrap, error and reset sequences.
module tb_apply_result_return;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int IDX_W = 30;

    typedef struct {
        logic             iv;
        logic             ih;
        logic [IDX_W-1:0] ir;
        logic             cv;
        logic [TAG_W-1:0] ct;
        logic [IDX_W-1:0] cr;
        logic             rr;
        logic             eRdy;
        logic [TAG_W-1:0] eTag;
        logic             eRv;
        logic [IDX_W-1:0] eRes;
        logic [TAG_W:0]   eOcc;
        logic             eErr;
    } vec_t;

    logic clk;
    logic resetn;
    int   nPass;
    int   nTotal;
    vec_t vecs [19];

    apply_result_return_if #(.TAG_W(TAG_W), .IDX_W(IDX_W)) bus ();

    apply_result_return #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int iv, input int ih, input int ir,
                                input int cv, input int ct, input int cr, input int rr,
                                input int eRdy, input int eTag, input int eRv,
                                input int eRes, input int eOcc, input int eErr);
        vec_t v;
        v.iv   = 1'(iv);
        v.ih   = 1'(ih);
        v.ir   = IDX_W'(ir);
        v.cv   = 1'(cv);
        v.ct   = TAG_W'(ct);
        v.cr   = IDX_W'(cr);
        v.rr   = 1'(rr);
        v.eRdy = 1'(eRdy);
        v.eTag = TAG_W'(eTag);
        v.eRv  = 1'(eRv);
        v.eRes = IDX_W'(eRes);
        v.eOcc = (TAG_W + 1)'(eOcc);
        v.eErr = 1'(eErr);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic checkOuts(input string nm, input int rdy, input int tag, input int rv,
                             input int res, input int occ, input int err);
        chk({nm, ".issue_ready"}, 32'(bus.issue_ready), 32'(rdy));
        chk({nm, ".issue_tag"},   32'(bus.issue_tag),   32'(tag));
        chk({nm, ".rsp_valid"},   32'(bus.rsp_valid),   32'(rv));
        chk({nm, ".rsp_result"},  32'(bus.rsp_result),  32'(res));
        chk({nm, ".occupancy"},   32'(bus.occupancy),   32'(occ));
        chk({nm, ".err_cmp"},     32'(bus.err_cmp),     32'(err));
    endtask

    task automatic drive(input int iv, input int ih, input int ir,
                         input int cv, input int ct, input int cr, input int rr);
        bus.issue_valid  = 1'(iv);
        bus.issue_hit    = 1'(ih);
        bus.issue_result = IDX_W'(ir);
        bus.cmp_valid    = 1'(cv);
        bus.cmp_tag      = TAG_W'(ct);
        bus.cmp_result   = IDX_W'(cr);
        bus.rsp_ready    = 1'(rr);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        nPass  = 0;
        nTotal = 0;
        resetn = 1'b0;
        idle();

        //          iv ih ir     cv ct cr     rr   rdy tag rv res    occ err
        vecs[0]  = mk(1, 1, 'h5,  0, 0, 0,     1,   1, 0, 0, 0,     0, 0);
        vecs[1]  = mk(0, 0, 0,    0, 0, 0,     1,   1, 1, 1, 'h5,   1, 0);
        vecs[2]  = mk(0, 0, 0,    0, 0, 0,     0,   1, 1, 0, 0,     0, 0);
        vecs[3]  = mk(1, 0, 0,    0, 0, 0,     0,   1, 1, 0, 0,     0, 0);
        vecs[4]  = mk(1, 1, 'h7,  0, 0, 0,     0,   1, 2, 0, 0,     1, 0);
        vecs[5]  = mk(1, 0, 0,    0, 0, 0,     0,   1, 3, 0, 0,     2, 0);
        vecs[6]  = mk(0, 0, 0,    1, 3, 'h33,  1,   1, 4, 0, 0,     3, 0);
        vecs[7]  = mk(0, 0, 0,    1, 1, 'h9,   1,   1, 4, 0, 0,     3, 0);
        vecs[8]  = mk(0, 0, 0,    0, 0, 0,     1,   1, 4, 1, 'h9,   3, 0);
        vecs[9]  = mk(0, 0, 0,    0, 0, 0,     1,   1, 4, 1, 'h7,   2, 0);
        vecs[10] = mk(0, 0, 0,    0, 0, 0,     0,   1, 4, 1, 'h33,  1, 0);
        vecs[11] = mk(0, 0, 0,    0, 0, 0,     1,   1, 4, 1, 'h33,  1, 0);
        vecs[12] = mk(1, 0, 0,    0, 0, 0,     0,   1, 4, 0, 0,     0, 0);
        vecs[13] = mk(1, 0, 0,    0, 0, 0,     0,   1, 5, 0, 0,     1, 0);
        vecs[14] = mk(0, 0, 0,    1, 4, 'h44,  0,   1, 6, 0, 0,     2, 0);
        vecs[15] = mk(1, 1, 'h66, 1, 5, 'h55,  1,   1, 6, 1, 'h44,  2, 0);
        vecs[16] = mk(0, 0, 0,    0, 0, 0,     1,   1, 7, 1, 'h55,  2, 0);
        vecs[17] = mk(0, 0, 0,    0, 0, 0,     1,   1, 7, 1, 'h66,  1, 0);
        vecs[18] = mk(0, 0, 0,    0, 0, 0,     0,   1, 7, 0, 0,     0, 0);

        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // hit passthrough, out-of-order completion, simultaneous issue/cmp/pop
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            checkOuts($sformatf("vec%0d", i), int'(vecs[i].eRdy), int'(vecs[i].eTag),
                      int'(vecs[i].eRv), int'(vecs[i].eRes), int'(vecs[i].eOcc),
                      int'(vecs[i].eErr));
            drive(int'(vecs[i].iv), int'(vecs[i].ih), int'(vecs[i].ir), int'(vecs[i].cv),
                  int'(vecs[i].ct), int'(vecs[i].cr), int'(vecs[i].rr));
        end

        // fill to full, no bypass on pop, tag wrap
        @(negedge clk);
        idle();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checkOuts($sformatf("fill%0d", i), 1, i, 0, 0, i, 0);
            drive(1, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        checkOuts("full", 0, 0, 0, 0, 8, 0);
        drive(1, 1, 'h3ff, 0, 0, 0, 0);
        @(negedge clk);
        checkOuts("fullBlocked", 0, 0, 0, 0, 8, 0);
        drive(0, 0, 0, 1, 0, 'h100, 0);
        @(negedge clk);
        checkOuts("fullHeadDone", 0, 0, 1, 'h100, 8, 0);
        drive(1, 1, 'h3ff, 0, 0, 0, 1);
        @(negedge clk);
        checkOuts("afterPop", 1, 0, 0, 0, 7, 0);

        // completion errors: free slot, then re-completing a done slot
        drive(0, 0, 0, 1, 0, 'hbad, 0);
        @(negedge clk);
        checkOuts("cmpFree", 1, 0, 0, 0, 7, 1);
        drive(0, 0, 0, 1, 1, 'h11, 0);
        @(negedge clk);
        checkOuts("cmpHead", 1, 0, 1, 'h11, 7, 1);
        drive(0, 0, 0, 1, 1, 'h22, 0);
        @(negedge clk);
        checkOuts("cmpAgain", 1, 0, 1, 'h11, 7, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOuts("popAfterErr", 1, 0, 0, 0, 6, 1);
        drive(0, 0, 0, 1, 2, 'h12, 0);
        @(negedge clk);
        checkOuts("cmpSlot2", 1, 0, 1, 'h12, 6, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOuts("fiveInFlight", 1, 0, 0, 0, 5, 1);
        idle();

        // asynchronous reset mid-operation, then a stale completion
        #2 resetn = 1'b0;
        #1 checkOuts("asyncReset", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 1, 3, 'h5, 0);
        @(negedge clk);
        checkOuts("lateCmp", 1, 0, 0, 0, 0, 1);
        idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
